hazard_controller: RTL and testbench

Pipeline hazard controller for the five-stage MIPS core. Observes register addresses and control bits in the D, E, M and W stages and produces the stall, flush and forwarding controls for the pipeline registers. Its FlushE output drives the CLR input of the ID/EX register. It also sequences multi-cycle data-memory accesses, with a timeout watchdog.

---
 rtl/hazard_pkg.sv | 22 ++
 rtl/forward_unit.sv | 47 ++++
 rtl/hazard_controller.sv | 211 +++++++++++++++++++++
 tb/tb_hazard_controller.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the pipeline hazard controller
//
// Purpose : FSM state encoding, execute-stage forward-select codes and the
//           default register-address width used by hazard_controller and
//           forward_unit.
// Ports   : none (package).

package hazard_pkg;

  localparam int REG_W_DEF = 6;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

endpackage

// File: rtl/forward_unit.sv
// rtl/forward_unit.sv - combinational operand-forwarding selection
//
// Purpose : Compares E- and D-stage source registers against the M and W
//           destinations and selects the bypass path. Register 0 is never
//           forwarded since it is hardwired to zero.
// Ports   : RsD, RtD         decode source registers
//           RsE, RtE         execute source registers
//           WriteRegM/W      memory / writeback destination registers
//           RegWriteM/W      memory / writeback write enables
//           ForwardAE/BE     execute operand select (FWD_RF/FWD_WB/FWD_MEM)
//           ForwardAD/BD     decode comparator forward from M

module forward_unit
  import hazard_pkg::*;
#(
  parameter int REG_W = REG_W_DEF
) (
  input  logic [REG_W-1:0] RsD,
  input  logic [REG_W-1:0] RtD,
  input  logic [REG_W-1:0] RsE,
  input  logic [REG_W-1:0] RtE,
  input  logic [REG_W-1:0] WriteRegM,
  input  logic             RegWriteM,
  input  logic [REG_W-1:0] WriteRegW,
  input  logic             RegWriteW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             ForwardAD,
  output logic             ForwardBD
);

  logic w_m_valid;
  logic w_w_valid;

  assign w_m_valid = RegWriteM && (WriteRegM != '0);
  assign w_w_valid = RegWriteW && (WriteRegW != '0);

  // M is the younger producer, so it wins over W.
  assign ForwardAE = (w_m_valid && (WriteRegM == RsE)) ? FWD_MEM :
                     (w_w_valid && (WriteRegW == RsE)) ? FWD_WB  : FWD_RF;
  assign ForwardBE = (w_m_valid && (WriteRegM == RtE)) ? FWD_MEM :
                     (w_w_valid && (WriteRegW == RtE)) ? FWD_WB  : FWD_RF;

  assign ForwardAD = w_m_valid && (WriteRegM == RsD);
  assign ForwardBD = w_m_valid && (WriteRegM == RtD);

endmodule

// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - stall/flush/forward control with memory-wait sequencing
//
// Purpose : Produces stall, flush and forwarding controls for the five-stage
//           pipeline, freezes the pipeline during multi-cycle data-memory
//           accesses and latches a sticky timeout error.
//           Optional macro HAZARD_STATS_EN adds saturating stall/flush counters.
// Ports   : clk, rst                       clock, synchronous active-high reset
//           RsD, RtD, BranchD, JumpD, PCSrcD decode-stage sources and control
//           RsE, RtE, WriteRegE, RegWriteE, MemtoRegE  execute-stage fields
//           WriteRegM, RegWriteM, MemtoRegM, MemReqM, MemReadyM  memory stage
//           WriteRegW, RegWriteW           writeback destination and enable
//           StallF/D/E/M, FlushD/E/W       pipeline register controls
//           ForwardAE/BE/AD/BD             forwarding selects
//           MemTimeout                     sticky memory-timeout error
//           StallCount, FlushCount         event counters (0 without stats)

module hazard_controller
  import hazard_pkg::*;
#(
  parameter int REG_W       = REG_W_DEF,
  parameter int MEM_TIMEOUT = 255          // must be >= 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] RsD,
  input  logic [REG_W-1:0] RtD,
  input  logic             BranchD,
  input  logic             JumpD,
  input  logic             PCSrcD,
  input  logic [REG_W-1:0] RsE,
  input  logic [REG_W-1:0] RtE,
  input  logic [REG_W-1:0] WriteRegE,
  input  logic             RegWriteE,
  input  logic             MemtoRegE,
  input  logic [REG_W-1:0] WriteRegM,
  input  logic             RegWriteM,
  input  logic             MemtoRegM,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  input  logic [REG_W-1:0] WriteRegW,
  input  logic             RegWriteW,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             ForwardAD,
  output logic             ForwardBD,
  output logic             MemTimeout,
  output logic [31:0]      StallCount,
  output logic [31:0]      FlushCount
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(MEM_TIMEOUT);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_wait_cnt;
  logic             r_timeout;

  logic       w_lwstall;
  logic       w_brstall;
  logic       w_freeze;
  logic       w_eval;
  logic [1:0] w_fwd_ae;
  logic [1:0] w_fwd_be;
  logic       w_fwd_ad;
  logic       w_fwd_bd;

  forward_unit #(.REG_W(REG_W)) u_forward_unit (
    .RsD       (RsD),
    .RtD       (RtD),
    .RsE       (RsE),
    .RtE       (RtE),
    .WriteRegM (WriteRegM),
    .RegWriteM (RegWriteM),
    .WriteRegW (WriteRegW),
    .RegWriteW (RegWriteW),
    .ForwardAE (w_fwd_ae),
    .ForwardBE (w_fwd_be),
    .ForwardAD (w_fwd_ad),
    .ForwardBD (w_fwd_bd)
  );

  assign ForwardAE = rst ? FWD_RF : w_fwd_ae;
  assign ForwardBE = rst ? FWD_RF : w_fwd_be;
  assign ForwardAD = rst ? 1'b0   : w_fwd_ad;
  assign ForwardBD = rst ? 1'b0   : w_fwd_bd;

  assign w_lwstall = MemtoRegE && ((RtE == RsD) || (RtE == RtD));
  assign w_brstall = BranchD &&
                     ((RegWriteE && ((WriteRegE == RsD) || (WriteRegE == RtD))) ||
                      (MemtoRegM && ((WriteRegM == RsD) || (WriteRegM == RtD))));

  always_comb begin
    w_state_nxt = r_state;
    w_freeze    = 1'b0;
    w_eval      = 1'b0;
    StallF      = 1'b0;
    StallD      = 1'b0;
    StallE      = 1'b0;
    StallM      = 1'b0;
    FlushD      = 1'b0;
    FlushE      = 1'b0;
    FlushW      = 1'b0;

    if (rst) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
      FlushW = 1'b1;
    end else begin
      case (r_state)
        RUN: begin
          // Freeze starts in the same cycle the slow access is seen.
          if (MemReqM && !MemReadyM) begin
            w_freeze    = 1'b1;
            w_state_nxt = MEM_WAIT;
          end else begin
            w_eval = 1'b1;
          end
        end
        MEM_WAIT: begin
          // Ready wins over a coincident timeout: the access completed.
          if (MemReadyM) begin
            w_eval      = 1'b1;
            w_state_nxt = RUN;
          end else begin
            w_freeze = 1'b1;
            if (r_wait_cnt == TIMEOUT_VAL) begin
              w_state_nxt = ERROR;
            end
          end
        end
        ERROR: begin
          w_freeze = 1'b1;
        end
        default: begin
          w_state_nxt = RUN;
        end
      endcase

      if (w_freeze) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else if (w_eval) begin
        // A stall suppresses a taken-branch flush; the branch is re-seen next cycle.
        if (w_lwstall || w_brstall) begin
          StallF = 1'b1;
          StallD = 1'b1;
          FlushE = 1'b1;
        end else if (PCSrcD || JumpD) begin
          FlushD = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= RUN;
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == MEM_WAIT) && (w_state_nxt == MEM_WAIT)) begin
        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
      end else begin
        r_wait_cnt <= '0;
      end
      if (w_state_nxt == ERROR) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign MemTimeout = r_timeout && !rst;

`ifdef HAZARD_STATS_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (StallF && (r_stall_cnt != 32'hFFFF_FFFF)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      if ((FlushD || FlushE) && (r_flush_cnt != 32'hFFFF_FFFF)) begin
        r_flush_cnt <= r_flush_cnt + 32'd1;
      end
    end
  end

  assign StallCount = r_stall_cnt;
  assign FlushCount = r_flush_cnt;
`else
  assign StallCount = '0;
  assign FlushCount = '0;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// tb/tb_hazard_controller.sv - self-checking bench for hazard_controller

module tb_hazard_controller;

  localparam int RW = 6;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [RW-1:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic          BranchD, JumpD, PCSrcD, RegWriteE, MemtoRegE;
  logic          RegWriteM, MemtoRegM, MemReqM, MemReadyM, RegWriteW;
  logic          StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
  logic [1:0]    ForwardAE, ForwardBE;
  logic          ForwardAD, ForwardBD, MemTimeout;
  logic [31:0]   StallCount, FlushCount;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state: plain flags and a cycle count of the current wait.
  bit          m_wait = 0;
  bit          m_err  = 0;
  int          m_cnt  = 0;
  int unsigned m_sc   = 0;
  int unsigned m_fc   = 0;

  always #5 clk = ~clk;

  hazard_controller #(.REG_W(RW), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .RsD(RsD), .RtD(RtD), .BranchD(BranchD), .JumpD(JumpD), .PCSrcD(PCSrcD),
    .RsE(RsE), .RtE(RtE), .WriteRegE(WriteRegE), .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE),
    .WriteRegM(WriteRegM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
    .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .WriteRegW(WriteRegW), .RegWriteW(RegWriteW),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .MemTimeout(MemTimeout), .StallCount(StallCount), .FlushCount(FlushCount)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] fwd_sel(input logic [RW-1:0] src);
    if (RegWriteM && WriteRegM != 0 && WriteRegM == src) return 2'b10;
    if (RegWriteW && WriteRegW != 0 && WriteRegW == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic hits(input logic [RW-1:0] dst);
    return (dst == RsD) || (dst == RtD);
  endfunction

  // Checks every output at the negedge against the model, then advances the model.
  task automatic cycle(input string tag);
    logic [1:0] e_ae, e_be;
    logic e_ad, e_bd, e_sf, e_sd, e_se, e_sm, e_fd, e_fe, e_fw, hz, frz;
    logic [31:0] e_sc, e_fc;
    @(negedge clk);
    hz  = (MemtoRegE && (RtE == RsD || RtE == RtD)) ||
          (BranchD && ((RegWriteE && hits(WriteRegE)) || (MemtoRegM && hits(WriteRegM))));
    frz = m_err || (m_wait ? !MemReadyM : (MemReqM && !MemReadyM));
    e_ae = fwd_sel(RsE);
    e_be = fwd_sel(RtE);
    e_ad = RegWriteM && WriteRegM != 0 && WriteRegM == RsD;
    e_bd = RegWriteM && WriteRegM != 0 && WriteRegM == RtD;
    if (rst) begin
      {e_sf, e_sd, e_se, e_sm} = 4'b0000;
      {e_fd, e_fe, e_fw} = 3'b111;
      e_ae = 2'b00; e_be = 2'b00; e_ad = 1'b0; e_bd = 1'b0;
    end else if (frz) begin
      {e_sf, e_sd, e_se, e_sm} = 4'b1111;
      {e_fd, e_fe, e_fw} = 3'b001;
    end else begin
      e_sf = hz; e_sd = hz; e_se = 1'b0; e_sm = 1'b0;
      e_fe = hz; e_fw = 1'b0;
      e_fd = !hz && (PCSrcD || JumpD);
    end
`ifdef HAZARD_STATS_EN
    e_sc = m_sc; e_fc = m_fc;
`else
    e_sc = 32'd0; e_fc = 32'd0;
`endif
    chk({tag, ".StallF"}, 32'(StallF), 32'(e_sf));
    chk({tag, ".StallD"}, 32'(StallD), 32'(e_sd));
    chk({tag, ".StallE"}, 32'(StallE), 32'(e_se));
    chk({tag, ".StallM"}, 32'(StallM), 32'(e_sm));
    chk({tag, ".FlushD"}, 32'(FlushD), 32'(e_fd));
    chk({tag, ".FlushE"}, 32'(FlushE), 32'(e_fe));
    chk({tag, ".FlushW"}, 32'(FlushW), 32'(e_fw));
    chk({tag, ".ForwardAE"}, 32'(ForwardAE), 32'(e_ae));
    chk({tag, ".ForwardBE"}, 32'(ForwardBE), 32'(e_be));
    chk({tag, ".ForwardAD"}, 32'(ForwardAD), 32'(e_ad));
    chk({tag, ".ForwardBD"}, 32'(ForwardBD), 32'(e_bd));
    chk({tag, ".MemTimeout"}, 32'(MemTimeout), 32'(m_err && !rst));
    chk({tag, ".StallCount"}, StallCount, e_sc);
    chk({tag, ".FlushCount"}, FlushCount, e_fc);
    if (rst) begin
      m_wait = 0; m_err = 0; m_cnt = 0; m_sc = 0; m_fc = 0;
    end else begin
      if (e_sf) m_sc++;
      if (e_fd || e_fe) m_fc++;
      if (!m_err) begin
        if (m_wait) begin
          if (MemReadyM) begin
            m_wait = 0; m_cnt = 0;
          end else if (m_cnt == TO) begin
            m_wait = 0; m_err = 1;
          end else begin
            m_cnt++;
          end
        end else if (MemReqM && !MemReadyM) begin
          m_wait = 1; m_cnt = 0;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    {RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW} = '0;
    {BranchD, JumpD, PCSrcD, RegWriteE, MemtoRegE} = '0;
    {RegWriteM, MemtoRegM, MemReqM, MemReadyM, RegWriteW} = '0;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    tick();
    cycle("reset");
    chk("reset_flushE", 32'(FlushE), 32'd1);
    chk("reset_stallF", 32'(StallF), 32'd0);
    tick();
    rst = 1'b0;

    // Three load-use stalls, then two jumps.
    for (int i = 0; i < 3; i++) begin
      MemtoRegE = 1'b1; RtE = 6'd3; RsD = 6'd3;
      cycle("lw_stall");
      chk("lw_stall_stallF", 32'(StallF), 32'd1);
      tick();
      MemtoRegE = 1'b0;
      cycle("lw_release");
      chk("lw_release_flushE", 32'(FlushE), 32'd0);
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      JumpD = 1'b1;
      cycle("jump");
      chk("jump_flushD", 32'(FlushD), 32'd1);
      tick();
      JumpD = 1'b0;
      cycle("jump_idle");
      tick();
    end
    cycle("stats");
`ifdef HAZARD_STATS_EN
    chk("stats_stall", StallCount, 32'd3);
    chk("stats_flush", FlushCount, 32'd5);
`else
    chk("stats_stall", StallCount, 32'd0);
    chk("stats_flush", FlushCount, 32'd0);
`endif
    tick();

    // Forwarding priority M over W.
    clear_inputs();
    RegWriteM = 1'b1; WriteRegM = 6'd5; RsE = 6'd5; RegWriteW = 1'b1; WriteRegW = 6'd5;
    cycle("fwd_mem");
    chk("fwd_mem_AE", 32'(ForwardAE), 32'd2);
    tick();
    WriteRegM = 6'd0;
    cycle("fwd_wb");
    chk("fwd_wb_AE", 32'(ForwardAE), 32'd1);
    tick();

    // Branch stall suppresses taken-branch flush.
    clear_inputs();
    BranchD = 1'b1; RegWriteE = 1'b1; WriteRegE = 6'd7; RtD = 6'd7; RsD = 6'd3; PCSrcD = 1'b1;
    cycle("br_stall");
    chk("br_stall_stallD", 32'(StallD), 32'd1);
    chk("br_stall_flushE", 32'(FlushE), 32'd1);
    chk("br_stall_flushD", 32'(FlushD), 32'd0);
    tick();

    // Four-cycle memory wait.
    clear_inputs();
    MemReqM = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle("mem_wait");
      chk("mem_wait_stallM", 32'(StallM), 32'd1);
      chk("mem_wait_flushW", 32'(FlushW), 32'd1);
      tick();
    end
    MemReadyM = 1'b1;
    cycle("mem_ready");
    chk("mem_ready_stallF", 32'(StallF), 32'd0);
    chk("mem_ready_stallM", 32'(StallM), 32'd0);
    tick();
    MemReqM = 1'b0;
    cycle("mem_idle");
    tick();

    // Timeout: one RUN freeze cycle plus TO+1 wait cycles, then ERROR.
    MemReqM = 1'b1; MemReadyM = 1'b0;
    for (int i = 0; i <= TO + 2; i++) begin
      cycle("timeout");
      chk("timeout_flag", 32'(MemTimeout), 32'(i >= TO + 2));
      tick();
    end
    MemReadyM = 1'b1;
    cycle("error_hold");
    chk("error_hold_stallF", 32'(StallF), 32'd1);
    chk("error_hold_flag", 32'(MemTimeout), 32'd1);
    tick();
    rst = 1'b1;
    cycle("error_rst");
    chk("error_rst_flag", 32'(MemTimeout), 32'd0);
    tick();
    rst = 1'b0; MemReqM = 1'b0; MemReadyM = 1'b0;
    cycle("after_rst");
    chk("after_rst_stallF", 32'(StallF), 32'd0);
    tick();

    // Reset in the middle of a wait.
    MemReqM = 1'b1;
    cycle("mid_wait0");
    tick();
    cycle("mid_wait1");
    tick();
    rst = 1'b1;
    cycle("mid_wait_rst");
    tick();
    rst = 1'b0; MemReqM = 1'b0;
    cycle("mid_wait_run");
    chk("mid_wait_run_stallM", 32'(StallM), 32'd0);
    tick();

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 199) == 0);
      RsD       = 6'($urandom_range(0, 7));
      RtD       = 6'($urandom_range(0, 7));
      RsE       = 6'($urandom_range(0, 7));
      RtE       = 6'($urandom_range(0, 7));
      WriteRegE = 6'($urandom_range(0, 7));
      WriteRegM = 6'($urandom_range(0, 7));
      WriteRegW = 6'($urandom_range(0, 7));
      BranchD   = 1'($urandom_range(0, 1));
      JumpD     = ($urandom_range(0, 7) == 0);
      PCSrcD    = 1'($urandom_range(0, 1));
      RegWriteE = 1'($urandom_range(0, 1));
      MemtoRegE = ($urandom_range(0, 3) == 0);
      RegWriteM = 1'($urandom_range(0, 1));
      MemtoRegM = ($urandom_range(0, 3) == 0);
      MemReqM   = ($urandom_range(0, 3) == 0);
      MemReadyM = ($urandom_range(0, 3) != 0);
      RegWriteW = 1'($urandom_range(0, 1));
      cycle("random");
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
